// File: rtl/circ_mtx_vec_mul_seq.sv
// Time-multiplexed circulant matrix-vector multiplier over GF(2^WORD_WIDTH - 1).
// LANES MAC units sweep the columns of one row group at a time; operands and results use valid/ready.
module circ_mtx_vec_mul_seq #(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned MTX_SIZE   = 16,
    parameter int unsigned LANES      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic [MTX_SIZE*WORD_WIDTH-1:0] mtx_row,
    input  logic [MTX_SIZE*WORD_WIDTH-1:0] vec,
    output logic [MTX_SIZE*WORD_WIDTH-1:0] result,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned W      = WORD_WIDTH;
    localparam int unsigned W1     = WORD_WIDTH + 1;
    localparam int unsigned W2     = 2 * WORD_WIDTH;
    localparam int unsigned N      = MTX_SIZE;
    localparam int unsigned GROUPS = MTX_SIZE / LANES;
    localparam int unsigned JW     = $clog2(MTX_SIZE);
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [W-1:0]  P      = {W{1'b1}};
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mode_q;
    logic [JW-1:0] j_q;
    logic [GW-1:0] g_q;
    logic [W-1:0]  mtx_q   [N];
    logic [W-1:0]  vec_q   [N];
    logic [W-1:0]  res_q   [N];
    logic [W-1:0]  acc_q   [LANES];
    logic [W-1:0]  acc_d   [LANES];
    logic [JW-1:0] row_r   [LANES];
    logic [JW-1:0] col_idx [LANES];
    logic          accept, j_last, g_last;

    // Product reduced to [0, p-1]: 2^W == 1 mod p, so hi and lo halves simply add.
    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W2-1:0] prod;
        logic [W1-1:0] s1;
        logic [W-1:0]  s2;
        prod = W2'(a) * W2'(b);
        s1   = W1'(prod[W2-1:W]) + W1'(prod[W-1:0]);
        s2   = W'(s1[W]) + s1[W-1:0];
        return (s2 == P) ? '0 : s2;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W1-1:0] s;
        s = W1'(a) + W1'(b);
        return (s >= {1'b0, P}) ? W'(s - {1'b0, P}) : s[W-1:0];
    endfunction

    assign accept = (state_q == S_IDLE) && in_valid && in_ready;
    assign j_last = (j_q == J_LAST);
    assign g_last = (g_q == G_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  if (j_last && g_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
        end
    end

    // Column select per lane; index arithmetic wraps mod 2^JW, exact since true values are < N.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            row_r[l] = JW'(g_q) * JW'(LANES) + JW'(l);
            if (mode_q) begin
                col_idx[l] = j_q + row_r[l];
                if ((row_r[l] != '0) && (j_q >= JW'(N) - row_r[l]))
                    col_idx[l] = j_q + row_r[l] - JW'(N);
            end else begin
                col_idx[l] = j_q - row_r[l];
                if (j_q < row_r[l])
                    col_idx[l] = j_q - row_r[l] + JW'(N);
            end
            acc_d[l] = mod_add(acc_q[l], mod_mul(mtx_q[col_idx[l]], vec_q[j_q]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            j_q    <= '0;
            g_q    <= '0;
            for (int i = 0; i < N; i++) begin
                mtx_q[i] <= '0;
                vec_q[i] <= '0;
                res_q[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else if (accept) begin
            mode_q <= mode;
            j_q    <= '0;
            g_q    <= '0;
            for (int i = 0; i < N; i++) begin
                mtx_q[i] <= mtx_row[i*W +: W];
                vec_q[i] <= vec[i*W +: W];
            end
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else if (state_q == S_CALC) begin
            if (j_last) begin
                j_q <= '0;
                if (!g_last) g_q <= g_q + GW'(1);
                for (int l = 0; l < LANES; l++) begin
                    res_q[row_r[l]] <= acc_d[l];
                    acc_q[l]        <= '0;
                end
            end else begin
                j_q <= j_q + JW'(1);
                for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign result[i*W +: W] = res_q[i];
    end

endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Scoreboard bench for circ_mtx_vec_mul_seq: directed N=16 tests plus N=4 random sweeps over LANES.
module tb_circ_mtx_vec_mul_seq;

    localparam int unsigned W   = 31;
    localparam int unsigned N   = 16;
    localparam int unsigned L   = 4;
    localparam int unsigned NW  = N * W;
    localparam int unsigned SN  = 4;
    localparam int unsigned LAT = N * N / L + 1;
    localparam logic [W-1:0] P  = 31'h7fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, sw_rst;
    logic          in_valid, in_ready, mode, out_valid, out_ready;
    logic [NW-1:0] mtx_row, vec, result;

    int errors = 0;
    int checks = 0;
    int sweep_done = 0;
    logic [NW-1:0] sb_q[$];

    circ_mtx_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(N), .LANES(L)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .mtx_row(mtx_row), .vec(vec), .result(result), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check_val(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference using plain % arithmetic.
    function automatic logic [NW-1:0] ref_mul(input logic [NW-1:0] m, input logic [NW-1:0] v,
                                              input logic md, input int n);
        logic [NW-1:0] r;
        longint unsigned acc, a, b;
        int idx;
        r = '0;
        for (int i = 0; i < n; i++) begin
            acc = 0;
            for (int j = 0; j < n; j++) begin
                idx = md ? (j + i) % n : (j - i + n) % n;
                a   = 64'(m[idx*W +: W]) % 64'(P);
                b   = 64'(v[j*W +: W]) % 64'(P);
                acc = (acc + (a * b) % 64'(P)) % 64'(P);
            end
            r[i*W +: W] = acc[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic send(input logic [NW-1:0] m, input logic [NW-1:0] v, input logic md,
                        input logic [NW-1:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_before_send", NW'(in_ready), NW'(1));
        mtx_row  = m;
        vec      = v;
        mode     = md;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int stall);
        int lat;
        logic [NW-1:0] snap, exp;
        lat = 1;
        while (!out_valid && lat < int'(LAT) + 50) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, NW'(lat), NW'(LAT));
        snap = result;
        for (int s = 0; s < stall; s++) begin
            mtx_row  = rand_vec();
            vec      = rand_vec();
            mode     = ~mode;
            in_valid = 1'b1;
            @(negedge clk);
            check_val({tag, "_stall_result"}, result, snap);
            check_val({tag, "_stall_in_ready"}, NW'(in_ready), NW'(0));
            check_val({tag, "_stall_out_valid"}, NW'(out_valid), NW'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~result;
        check_val(tag, result, exp);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_out_valid_drop"}, NW'(out_valid), NW'(0));
        check_val({tag, "_in_ready_rise"}, NW'(in_ready), NW'(1));
    endtask

    // N=4 sweep instances over LANES in {1,2,4}
    for (genvar k = 0; k < 3; k++) begin : g_sweep
        localparam int unsigned SL = 1 << k;
        logic s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready;
        logic [SN*W-1:0] s_row, s_vec, s_res;
        logic [SN*W-1:0] sq[$];

        circ_mtx_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(SN), .LANES(SL)) u_sdut (
            .clk(clk), .reset(sw_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(s_mode),
            .mtx_row(s_row), .vec(s_vec), .result(s_res), .out_valid(s_out_valid),
            .out_ready(s_out_ready)
        );

        initial begin
            logic [NW-1:0] full;
            int lat, n;
            s_in_valid = 1'b0; s_out_ready = 1'b0; s_mode = 1'b0;
            s_row = '0; s_vec = '0;
            @(posedge sw_rst);
            @(negedge clk);
            for (int t = 0; t < 1000; t++) begin
                n = 0;
                while (!s_in_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check_val($sformatf("sweep_l%0d_in_ready", SL), NW'(s_in_ready), NW'(1));
                for (int e = 0; e < int'(SN); e++) begin
                    s_row[e*W +: W] = ($urandom_range(0, 7) == 0) ? P : W'($urandom);
                    s_vec[e*W +: W] = ($urandom_range(0, 7) == 0) ? P : W'($urandom);
                end
                s_mode = 1'($urandom_range(0, 1));
                full = ref_mul(NW'(s_row), NW'(s_vec), s_mode, SN);
                sq.push_back(full[SN*W-1:0]);
                s_in_valid = 1'b1;
                @(negedge clk);
                s_in_valid = 1'b0;
                lat = 1;
                while (!s_out_valid && lat < 100) begin
                    @(negedge clk);
                    lat++;
                end
                check_val($sformatf("sweep_l%0d_latency", SL), NW'(lat), NW'(SN * SN / SL + 1));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                s_out_ready = 1'b1;
                check_val($sformatf("sweep_l%0d_result", SL), NW'(s_res), NW'(sq.pop_front()));
                @(negedge clk);
                s_out_ready = 1'b0;
            end
            sweep_done++;
        end
    end

    initial begin
        logic [NW-1:0] m, v, e;
        int n;
        reset = 1'b0; sw_rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        mtx_row = '0; vec = '0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", NW'(in_ready), NW'(0));
        check_val("rst_out_valid", NW'(out_valid), NW'(0));
        check_val("rst_result", result, '0);
        reset = 1'b1; sw_rst = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", NW'(in_ready), NW'(1));

        for (int i = 0; i < int'(N); i++) v[i*W +: W] = W'(i);
        m = '0; m[W-1:0] = W'(1);
        send(m, v, 1'b0, v);
        collect("identity", 0);

        m = '0; m[W +: W] = W'(1);
        for (int i = 0; i < int'(N); i++) e[i*W +: W] = W'((i + 1) % 16);
        send(m, v, 1'b0, e);
        collect("shift_mode0", 0);
        for (int i = 0; i < int'(N); i++) e[i*W +: W] = W'((17 - i) % 16);
        send(m, v, 1'b1, e);
        collect("shift_mode1", 0);

        for (int i = 0; i < int'(N); i++) begin
            m[i*W +: W] = P - W'(1);
            v[i*W +: W] = W'(1);
            e[i*W +: W] = W'(2147483631);
        end
        send(m, v, 1'b0, e);
        collect("wrap_pm1", 0);
        for (int i = 0; i < int'(N); i++) m[i*W +: W] = P;
        send(m, rand_vec(), 1'b1, '0);
        collect("wrap_all_p", 0);

        m = rand_vec(); v = rand_vec();
        send(m, v, 1'b0, ref_mul(m, v, 1'b0, N));
        collect("backpressure", 20);
        repeat (3) begin
            @(negedge clk);
            check_val("backpressure_single_txn", NW'(out_valid), NW'(0));
        end

        for (int i = 0; i < int'(N); i++) v[i*W +: W] = W'(i);
        m = '0; m[W-1:0] = W'(1);
        send(m, v, 1'b0, v);
        repeat (29) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midreset_out_valid", NW'(out_valid), NW'(0));
        check_val("midreset_result", result, '0);
        check_val("midreset_in_ready", NW'(in_ready), NW'(0));
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midreset_release_in_ready", NW'(in_ready), NW'(1));
        send(m, v, 1'b0, v);
        collect("identity_after_reset", 0);

        for (int t = 0; t < 5; t++) begin
            m = rand_vec(); v = rand_vec();
            send(m, v, 1'(t), ref_mul(m, v, 1'(t), N));
            collect("random16", t);
        end

        n = 0;
        while (sweep_done < 3 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check_val("sweep_complete", NW'(sweep_done), NW'(3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
